// File: rtl/mask_scheduler.sv
// mask_scheduler
// Shares one sparsity-mask unit among NREQ requesters. Jobs are granted
// round-robin, issued to the unit with a one-cycle input_ready pulse, and the
// unit's result (o_mask plus xor residues) is returned to the job owner over
// a valid/ready channel. At most one job is in flight.
//
// Ports
//   clk, reset               clock; synchronous active-high reset
//   req_valid/req_ready      per-requester job request / one-hot grant pulse
//   req_i_mask/req_w_mask    packed masks, requester k at [k*LENGTH +: LENGTH]
//   resp_valid/resp_ready    one-hot result valid to owner / per-requester accept
//   resp_mask/xor_i/xor_w    captured unit results, held until the next capture
//   unit_*                   mask unit interface (unit_state: 00 idle, 01 busy, 10 done)
//   job_count/busy_cycles    statistics, live only with MASK_SCHED_STATS_EN
//
// Build option: define MASK_SCHED_STATS_EN to enable the job and busy-cycle
// counters; otherwise both outputs are tied to zero.
//
// state   | meaning
// S_IDLE  | waiting for a request while the unit is idle
// S_ISSUE | presenting latched masks with unit_input_ready
// S_WAIT  | unit computing; capture result when it reports done
// S_RESP  | resp_valid to owner until its resp_ready
module mask_scheduler #(
    parameter  int LENGTH = 32,
    parameter  int NREQ   = 4,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*LENGTH-1:0] req_i_mask,
    input  logic [NREQ*LENGTH-1:0] req_w_mask,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        resp_valid,
    input  logic [NREQ-1:0]        resp_ready,
    output logic [LENGTH-1:0]      resp_mask,
    output logic [LENGTH-1:0]      resp_xor_i,
    output logic [LENGTH-1:0]      resp_xor_w,
    output logic [LENGTH-1:0]      unit_i_mask,
    output logic [LENGTH-1:0]      unit_w_mask,
    output logic                   unit_input_ready,
    output logic                   unit_output_taken,
    input  logic [LENGTH-1:0]      unit_o_mask,
    input  logic [LENGTH-1:0]      unit_xor_i_mask,
    input  logic [LENGTH-1:0]      unit_xor_w_mask,
    input  logic [1:0]             unit_state,
    output logic [15:0]            job_count,
    output logic [31:0]            busy_cycles
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state_q;
    logic [IDW-1:0]    rr_ptr_q;
    logic [IDW-1:0]    rr_ptr_d;
    logic [IDW-1:0]    owner_q;
    logic [LENGTH-1:0] i_lat_q;
    logic [LENGTH-1:0] w_lat_q;
    logic [LENGTH-1:0] resp_mask_q;
    logic [LENGTH-1:0] resp_xor_i_q;
    logic [LENGTH-1:0] resp_xor_w_q;

    logic              grant;
    logic              found;
    logic              resp_hs;
    logic [IDW-1:0]    winner;
    int                idx;

    // Round-robin search starting at rr_ptr_q, wrapping NREQ-1 -> 0.
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[IDW'(idx)]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    // Gated by reset so no grant pulse leaks out while reset is held.
    assign grant    = !reset && (state_q == S_IDLE) && (|req_valid) && (unit_state == 2'b00);
    assign resp_hs  = (state_q == S_RESP) && resp_ready[owner_q];
    assign rr_ptr_d = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);

    assign req_ready         = grant ? (NREQ'(1) << winner) : '0;
    assign resp_valid        = (state_q == S_RESP) ? (NREQ'(1) << owner_q) : '0;
    assign unit_input_ready  = (state_q == S_ISSUE);
    assign unit_output_taken = (state_q == S_WAIT) && (unit_state == 2'b10);
    assign unit_i_mask       = i_lat_q;
    assign unit_w_mask       = w_lat_q;
    assign resp_mask         = resp_mask_q;
    assign resp_xor_i        = resp_xor_i_q;
    assign resp_xor_w        = resp_xor_w_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            i_lat_q      <= '0;
            w_lat_q      <= '0;
            resp_mask_q  <= '0;
            resp_xor_i_q <= '0;
            resp_xor_w_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        owner_q <= winner;
                        i_lat_q <= req_i_mask[winner*LENGTH +: LENGTH];
                        w_lat_q <= req_w_mask[winner*LENGTH +: LENGTH];
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    // Capture in the same cycle output_taken is pulsed.
                    if (unit_state == 2'b10) begin
                        resp_mask_q  <= unit_o_mask;
                        resp_xor_i_q <= unit_xor_i_mask;
                        resp_xor_w_q <= unit_xor_w_mask;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_hs) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef MASK_SCHED_STATS_EN
    logic [15:0] job_count_q;
    logic [31:0] busy_cycles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            job_count_q   <= '0;
            busy_cycles_q <= '0;
        end else begin
            if (resp_hs) job_count_q <= job_count_q + 16'd1;
            if (state_q != S_IDLE && busy_cycles_q != 32'hFFFF_FFFF)
                busy_cycles_q <= busy_cycles_q + 32'd1;
        end
    end

    assign job_count   = job_count_q;
    assign busy_cycles = busy_cycles_q;
`else
    assign job_count   = '0;
    assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_mask_scheduler.sv
// tb_mask_scheduler
// Directed bench for mask_scheduler with a behavioural 4-cycle mask unit
// (o = i & w, xor_i = i ^ o, xor_w = w ^ o). Inputs change on the falling
// edge; outputs are sampled 1 time unit later.
module tb_mask_scheduler;

    localparam int LENGTH = 32;
    localparam int NREQ   = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*LENGTH-1:0] req_i_mask;
    logic [NREQ*LENGTH-1:0] req_w_mask;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        resp_valid;
    logic [NREQ-1:0]        resp_ready;
    logic [LENGTH-1:0]      resp_mask;
    logic [LENGTH-1:0]      resp_xor_i;
    logic [LENGTH-1:0]      resp_xor_w;
    logic [LENGTH-1:0]      unit_i_mask;
    logic [LENGTH-1:0]      unit_w_mask;
    logic                   unit_input_ready;
    logic                   unit_output_taken;
    logic [LENGTH-1:0]      unit_o_mask;
    logic [LENGTH-1:0]      unit_xor_i_mask;
    logic [LENGTH-1:0]      unit_xor_w_mask;
    logic [1:0]             unit_state;
    logic [15:0]            job_count;
    logic [31:0]            busy_cycles;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mask_scheduler #(.LENGTH(LENGTH), .NREQ(NREQ)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_i_mask        (req_i_mask),
        .req_w_mask        (req_w_mask),
        .req_ready         (req_ready),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_mask         (resp_mask),
        .resp_xor_i        (resp_xor_i),
        .resp_xor_w        (resp_xor_w),
        .unit_i_mask       (unit_i_mask),
        .unit_w_mask       (unit_w_mask),
        .unit_input_ready  (unit_input_ready),
        .unit_output_taken (unit_output_taken),
        .unit_o_mask       (unit_o_mask),
        .unit_xor_i_mask   (unit_xor_i_mask),
        .unit_xor_w_mask   (unit_xor_w_mask),
        .unit_state        (unit_state),
        .job_count         (job_count),
        .busy_cycles       (busy_cycles)
    );

    // Behavioural mask unit: input_ready -> busy 2 cycles -> done until taken.
    logic [1:0]  m_state;
    int          m_cnt;
    logic [31:0] m_o, m_xi, m_xw;
    logic        force_busy;

    always @(posedge clk) begin
        if (reset) begin
            m_state <= 2'b00;
            m_cnt   <= 0;
            m_o     <= '0;
            m_xi    <= '0;
            m_xw    <= '0;
        end else begin
            case (m_state)
                2'b00: if (unit_input_ready) begin
                    m_state <= 2'b01;
                    m_cnt   <= 1;
                    m_o     <= unit_i_mask & unit_w_mask;
                    m_xi    <= unit_i_mask ^ (unit_i_mask & unit_w_mask);
                    m_xw    <= unit_w_mask ^ (unit_i_mask & unit_w_mask);
                end
                2'b01: if (m_cnt == 0) m_state <= 2'b10; else m_cnt <= m_cnt - 1;
                2'b10: if (unit_output_taken) m_state <= 2'b00;
                default: m_state <= 2'b00;
            endcase
        end
    end

    assign unit_state      = force_busy ? 2'b01 : m_state;
    assign unit_o_mask     = (m_state == 2'b10) ? m_o  : 32'hDEAD_BEEF;
    assign unit_xor_i_mask = (m_state == 2'b10) ? m_xi : 32'hDEAD_BEEF;
    assign unit_xor_w_mask = (m_state == 2'b10) ? m_xw : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_resp(input string tag);
        int n;
        n = 0;
        cyc(); #1;
        while (resp_valid == '0 && n < 30) begin
            cyc(); #1;
            n++;
        end
        if (resp_valid == '0) begin
            vectors++;
            errors++;
            $error("FAIL %s: resp_valid observed %h expected nonzero within 30 cycles", tag, resp_valid);
        end
    endtask

    logic [3:0]  order [5];
    logic [31:0] exp_o [4];
    logic [31:0] exp_xi[4];
    logic [31:0] exp_xw[4];

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_i_mask = '0;
        req_w_mask = '0;
        resp_ready = '0;
        force_busy = 1'b0;

        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        exp_o[0] = 32'h0000_00FF; exp_xi[0] = 32'h0000_FF00; exp_xw[0] = 32'h00FF_0000;
        exp_o[1] = 32'h1234_0000; exp_xi[1] = 32'h0000_5678; exp_xw[1] = 32'hEDCB_0000;
        exp_o[2] = 32'h0000_AAAA; exp_xi[2] = 32'hAAAA_0000; exp_xw[2] = 32'h5555_5555;
        exp_o[3] = 32'h8000_0001; exp_xi[3] = 32'h7FFF_FFFE; exp_xw[3] = 32'h0000_0000;

        repeat (3) cyc();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_input_ready", 32'(unit_input_ready), 32'h0);
        chk("rst_resp_mask", resp_mask, 32'h0);

        // Single job from requester 0.
        cyc();
        reset = 1'b0;
        req_valid = 4'b0001;
        req_i_mask[0 +: 32] = 32'hF0F0_F0F0;
        req_w_mask[0 +: 32] = 32'hFF00_FF00;
        resp_ready = 4'b0001;
        #1;
        chk("t2_grant", 32'(req_ready), 32'h1);
        cyc(); req_valid = '0; #1;
        chk("t2_issue_ir", 32'(unit_input_ready), 32'h1);
        chk("t2_issue_imask", unit_i_mask, 32'hF0F0_F0F0);
        chk("t2_issue_wmask", unit_w_mask, 32'hFF00_FF00);
        chk("t2_grant_once", 32'(req_ready), 32'h0);
        cyc(); #1;
        chk("t2_ir_pulse", 32'(unit_input_ready), 32'h0);
        cyc(); cyc(); #1;
        chk("t2_taken", 32'(unit_output_taken), 32'h1);
        chk("t2_no_resp_yet", 32'(resp_valid), 32'h0);
        cyc(); #1;
        chk("t2_resp_valid", 32'(resp_valid), 32'h1);
        chk("t2_resp_mask", resp_mask, 32'hF000_F000);
        chk("t2_resp_xor_i", resp_xor_i, 32'h00F0_00F0);
        chk("t2_resp_xor_w", resp_xor_w, 32'h0F00_0F00);
        chk("t2_taken_pulse", 32'(unit_output_taken), 32'h0);
        cyc(); #1;
        chk("t2_resp_done", 32'(resp_valid), 32'h0);
        chk("t2_resp_held", resp_mask, 32'hF000_F000);

        // Reset held 3 cycles while the job is in S_WAIT.
        cyc();
        req_valid = 4'b0010;
        req_i_mask[32 +: 32] = 32'h1234_5678;
        req_w_mask[32 +: 32] = 32'hFFFF_0000;
        resp_ready = 4'b1111;
        #1;
        chk("t1_grant", 32'(req_ready), 32'h2);
        cyc(); req_valid = '0;
        cyc(); cyc();
        reset = 1'b1;
        repeat (3) cyc();
        #1;
        chk("t1_req_ready", 32'(req_ready), 32'h0);
        chk("t1_resp_valid", 32'(resp_valid), 32'h0);
        chk("t1_input_ready", 32'(unit_input_ready), 32'h0);
        chk("t1_output_taken", 32'(unit_output_taken), 32'h0);
        chk("t1_resp_mask", resp_mask, 32'h0);
        chk("t1_resp_xor_i", resp_xor_i, 32'h0);
        chk("t1_unit_i_mask", unit_i_mask, 32'h0);
        chk("t1_unit_w_mask", unit_w_mask, 32'h0);
        chk("t1_job_count", 32'(job_count), 32'h0);
        chk("t1_busy_cycles", busy_cycles, 32'h0);
        cyc(); reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc(); #1;
            chk("t1_no_resp_after", 32'(resp_valid), 32'h0);
        end

        // All four requesting: round-robin 0,1,2,3,0.
        req_i_mask[0  +: 32] = 32'h0000_FFFF; req_w_mask[0  +: 32] = 32'h00FF_00FF;
        req_i_mask[32 +: 32] = 32'h1234_5678; req_w_mask[32 +: 32] = 32'hFFFF_0000;
        req_i_mask[64 +: 32] = 32'hAAAA_AAAA; req_w_mask[64 +: 32] = 32'h5555_FFFF;
        req_i_mask[96 +: 32] = 32'hFFFF_FFFF; req_w_mask[96 +: 32] = 32'h8000_0001;
        cyc();
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("t3_grant_order", 32'(req_ready), 32'(order[j]));
            wait_resp("t3_resp_wait");
            chk("t3_resp_owner", 32'(resp_valid), 32'(order[j]));
            chk("t3_resp_mask", resp_mask, exp_o[j % 4]);
            chk("t3_resp_xor_i", resp_xor_i, exp_xi[j % 4]);
            chk("t3_resp_xor_w", resp_xor_w, exp_xw[j % 4]);
            cyc();
            if (j == 4) req_valid = '0;
        end

        // Unit busy blocks the grant until it returns to idle.
        resp_ready = '0;
        force_busy = 1'b1;
        req_valid  = 4'b0100;
        #1;
        chk("t4_blocked", 32'(req_ready), 32'h0);
        for (int c = 0; c < 4; c++) begin
            cyc(); #1;
            chk("t4_blocked", 32'(req_ready), 32'h0);
        end
        cyc(); force_busy = 1'b0; #1;
        chk("t4_grant_on_idle", 32'(req_ready), 32'h4);
        cyc(); req_valid = 4'b0001; #1;
        chk("t4_no_regrant_issue", 32'(req_ready), 32'h0);
        wait_resp("t4_resp_wait");
        chk("t4_resp_owner", 32'(resp_valid), 32'h4);
        chk("t4_resp_mask", resp_mask, 32'h0000_AAAA);

        // Response stall; non-owner resp_ready bits must be ignored.
        resp_ready = 4'b1011;
        for (int c = 0; c < 10; c++) begin
            cyc(); #1;
            chk("t5_resp_valid", 32'(resp_valid), 32'h4);
            chk("t5_resp_mask", resp_mask, 32'h0000_AAAA);
            chk("t5_resp_xor_w", resp_xor_w, 32'h5555_5555);
            chk("t5_input_ready", 32'(unit_input_ready), 32'h0);
            chk("t5_req_ready", 32'(req_ready), 32'h0);
        end
        cyc(); resp_ready = 4'b0100;
        cyc(); resp_ready = 4'b1111; #1;
        chk("t5_regrant", 32'(req_ready), 32'h1);
        chk("t5_resp_cleared", 32'(resp_valid), 32'h0);
        chk("t5_resp_kept", resp_mask, 32'h0000_AAAA);
        cyc(); req_valid = '0;
        wait_resp("t5_next_wait");
        chk("t5_next_owner", 32'(resp_valid), 32'h1);
        chk("t5_next_mask", resp_mask, 32'h0000_00FF);
        cyc();

`ifdef MASK_SCHED_STATS_EN
        // 5 jobs with a 3-cycle stall: ISSUE 1 + WAIT 3 + RESP 4 = 8 busy cycles each.
        reset = 1'b1;
        resp_ready = '0;
        cyc(); cyc();
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            req_valid = 4'b0001;
            #1;
            chk("t6_grant", 32'(req_ready), 32'h1);
            cyc(); req_valid = '0;
            wait_resp("t6_resp_wait");
            cyc(); cyc();
            cyc(); resp_ready = 4'b0001;
            cyc(); resp_ready = '0;
        end
        #1;
        chk("t6_job_count", 32'(job_count), 32'd5);
        chk("t6_busy_cycles", busy_cycles, 32'd40);
`else
        #1;
        chk("stats_off_job_count", 32'(job_count), 32'h0);
        chk("stats_off_busy_cycles", busy_cycles, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
